// File: rtl/matrix_loader_if.sv
// Handshake and operand bundle between the byte-stream feeder, matrix_loader
// and matrix_mult. The master side drives the byte stream and mm_done; the
// slave side (matrix_loader) drives ready, operands, start, busy and err.
interface matrix_loader_if #(
   parameter int DIM = 8,
   parameter int DW  = 8
);
   logic                             in_valid;
   logic [DW-1:0]                    in_data;
   logic                             in_ready;
   logic [DIM-1:0][DIM-1:0][DW-1:0]  a_data;
   logic [DIM-1:0][DW-1:0]           b_data;
   logic                             start;
   logic                             mm_done;
   logic                             busy;
   logic                             err;

   modport master (
      output in_valid, in_data, mm_done,
      input  in_ready, a_data, b_data, start, busy, err
   );

   modport slave (
      input  in_valid, in_data, mm_done,
      output in_ready, a_data, b_data, start, busy, err
   );
endinterface

// File: rtl/matrix_loader.sv
// matrix_loader: assembles a DIM x DIM matrix A (row-major) and a DIM-element
// vector B from a valid/ready byte stream, pulses start to matrix_mult for one
// cycle and holds the operands until mm_done.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailer byte equal
// to the mod-2^DW sum of all A and B bytes before start is issued.
module matrix_loader #(
   parameter int DIM = 8,
   parameter int DW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   matrix_loader_if.slave   bus
);
   localparam int IDX_W = $clog2(DIM*DIM+1);
   localparam int RC_W  = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [IDX_W-1:0] LAST_A = IDX_W'(DIM*DIM-1);
   localparam logic [IDX_W-1:0] LAST_B = IDX_W'(DIM-1);

   typedef enum logic [2:0] {
      S_LOAD_A,
      S_LOAD_B,
`ifdef LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_FIRE,
      S_WAIT
   } state_t;

   state_t                           state_q, state_d;
   logic [IDX_W-1:0]                 idx_q, idx_d;
   logic [DIM-1:0][DIM-1:0][DW-1:0]  a_q, a_d;
   logic [DIM-1:0][DW-1:0]           b_q, b_d;
   logic                             busy_q, busy_d;
`ifdef LOADER_CHECKSUM_EN
   logic [DW-1:0]                    sum_q, sum_d;
   logic                             err_q, err_d;
`endif

   logic              beat;
   logic [RC_W-1:0]   row;
   logic [RC_W-1:0]   col;

   // Ready and start are pure decodes of the registered state, so start has
   // no combinational path from the upstream inputs.
`ifdef LOADER_CHECKSUM_EN
   assign bus.in_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) || (state_q == S_CHK);
   assign bus.err      = err_q;
`else
   assign bus.in_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
   assign bus.err      = 1'b0;
`endif
   assign bus.start  = (state_q == S_FIRE);
   assign bus.busy   = busy_q;
   assign bus.a_data = a_q;
   assign bus.b_data = b_q;

   assign beat = bus.in_valid & bus.in_ready;
   assign row  = RC_W'(idx_q / IDX_W'(DIM));
   assign col  = RC_W'(idx_q % IDX_W'(DIM));

   // Next-state, index, operand and status computation; clr overrides everything.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      busy_d  = busy_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d   = sum_q;
      err_d   = err_q;
`endif
      if (clr) begin
         state_d = S_LOAD_A;
         idx_d   = '0;
         a_d     = '0;
         b_d     = '0;
         busy_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_d   = '0;
         err_d   = 1'b0;
`endif
      end else begin
         case (state_q)
            S_LOAD_A: begin
               if (beat) begin
                  if (idx_q == '0) busy_d = 1'b1;
                  a_d[row][col] = bus.in_data;
`ifdef LOADER_CHECKSUM_EN
                  sum_d = sum_q + bus.in_data;
`endif
                  if (idx_q == LAST_A) begin
                     idx_d   = '0;
                     state_d = S_LOAD_B;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            S_LOAD_B: begin
               if (beat) begin
                  b_d[col] = bus.in_data;
`ifdef LOADER_CHECKSUM_EN
                  sum_d = sum_q + bus.in_data;
`endif
                  if (idx_q == LAST_B) begin
                     idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
                     state_d = S_CHK;
`else
                     state_d = S_FIRE;
`endif
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
               if (beat) begin
                  if (bus.in_data == sum_q) begin
                     state_d = S_FIRE;
                  end else begin
                     // No start will follow, so no mm_done will ever clear busy.
                     err_d   = 1'b1;
                     busy_d  = 1'b0;
                     sum_d   = '0;
                     state_d = S_LOAD_A;
                  end
               end
            end
`endif
            S_FIRE: begin
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (bus.mm_done) begin
                  busy_d  = 1'b0;
                  state_d = S_LOAD_A;
`ifdef LOADER_CHECKSUM_EN
                  sum_d   = '0;
`endif
               end
            end
            default: begin
               state_d = S_LOAD_A;
               idx_d   = '0;
            end
         endcase
      end
   end

   // State and operand registers; rst restores every reset value and beats clr.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_LOAD_A;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
         err_q   <= err_d;
`endif
      end
   end
endmodule
